// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, byte-sequencer phases, opcode class helper.
// FETCH_ROM_LIMIT_EN adds the FAULT state used by the ROM-limit check.
package cpu_pkg;

  localparam logic [1:0] CPUSTATE_RUN = 2'b11;
  localparam logic [3:0] OP_MVRD_HI   = 4'b1010;

  typedef enum logic [3:0] {
    IDLE,
    OP_ADDR,
    OP_RD,
    OP_CAP,
    IM_ADDR,
    IM_RD,
    IM_CAP,
    HOLD
`ifdef FETCH_ROM_LIMIT_EN
    , FAULT
`endif
  } fetch_state_e;

  typedef enum logic [1:0] {
    BP_NONE,
    BP_ADDR,
    BP_RD,
    BP_CAP
  } byte_phase_e;

  function automatic logic [15:0] instr_len(input logic [7:0] op);
    return (op[7:4] == OP_MVRD_HI) ? 16'd2 : 16'd1;
  endfunction

endpackage

// File: rtl/fetch_byte_seq.sv
// Memory-side address/read/capture sequencer for one byte; driven by the fetch FSM's
// next phase so mem_addr and mem_read come straight from registers.
module fetch_byte_seq
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  byte_phase_e phase_d_i,
  input  logic [15:0] addr_d_i,
  input  logic [7:0]  mem_data_i,
  output logic [15:0] mem_addr_o,
  output logic        mem_read_o,
  output logic [7:0]  data_o
);

  logic [15:0] addr_q;
  logic        read_q;

  // Address only moves in the ADDR phase, so read always rises on a settled address.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q <= RESET_ADDR;
      read_q <= 1'b0;
    end else begin
      read_q <= (phase_d_i == BP_RD) || (phase_d_i == BP_CAP);
      if (phase_d_i == BP_ADDR) addr_q <= addr_d_i;
    end
  end

  assign mem_addr_o = addr_q;
  assign mem_read_o = read_q;
  assign data_o     = mem_data_i;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetches opcode (+ immediate for MVRD) and holds it for the decoder.
// FETCH_ROM_LIMIT_EN enables the sticky fault on fetch addresses above ROM_TOP.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
`ifdef FETCH_ROM_LIMIT_EN
  , parameter logic [15:0] ROM_TOP = 16'h001F
`endif
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        run_en_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_addr_i,
  output logic [15:0] mem_addr_o,
  output logic        mem_read_o,
  input  logic [7:0]  mem_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [7:0]  instr_op_o,
  output logic [7:0]  instr_imm_o,
  output logic [15:0] instr_pc_o,
  output logic [15:0] pc_o,
  output logic        fault_o
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d, ipc_q, ipc_d, addr_d, go_addr;
  logic [7:0]   op_q, op_d, imm_q, imm_d, seq_byte;
  logic         valid_q, valid_d, go_fetch, go_imm;
  byte_phase_e  phase_d;
`ifdef FETCH_ROM_LIMIT_EN
  logic         fault_q, fault_d;
`endif

  fetch_byte_seq #(.RESET_ADDR(RESET_PC)) u_seq (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .phase_d_i  (phase_d),
    .addr_d_i   (addr_d),
    .mem_data_i (mem_data_i),
    .mem_addr_o (mem_addr_o),
    .mem_read_o (mem_read_o),
    .data_o     (seq_byte)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ipc_d    = ipc_q;
    op_d     = op_q;
    imm_d    = imm_q;
    valid_d  = valid_q;
    phase_d  = BP_NONE;
    addr_d   = pc_q;
    go_fetch = 1'b0;
    go_imm   = 1'b0;
    go_addr  = pc_q;
`ifdef FETCH_ROM_LIMIT_EN
    fault_d  = fault_q;
`endif
    if (redirect_i) begin
      pc_d    = redirect_addr_i;
      valid_d = 1'b0;
      state_d = IDLE;
`ifdef FETCH_ROM_LIMIT_EN
      fault_d = 1'b0;
`endif
      if (run_en_i) begin
        go_fetch = 1'b1;
        go_addr  = redirect_addr_i;
      end
    end else begin
      unique case (state_q)
        IDLE: go_fetch = run_en_i;
        OP_ADDR, IM_ADDR: begin
          if (!run_en_i) state_d = IDLE;
          else begin
            state_d = (state_q == OP_ADDR) ? OP_RD : IM_RD;
            phase_d = BP_RD;
          end
        end
        OP_RD, IM_RD: begin
          if (!run_en_i) state_d = IDLE;
          else begin
            state_d = (state_q == OP_RD) ? OP_CAP : IM_CAP;
            phase_d = BP_CAP;
          end
        end
        OP_CAP: begin
          if (!run_en_i) state_d = IDLE;
          else begin
            op_d  = seq_byte;
            ipc_d = pc_q;
            imm_d = 8'h00;
            if (seq_byte[7:4] == OP_MVRD_HI) begin
              go_fetch = 1'b1;
              go_imm   = 1'b1;
              go_addr  = pc_q + 16'd1;
            end else begin
              state_d = HOLD;
              valid_d = 1'b1;
            end
          end
        end
        IM_CAP: begin
          if (!run_en_i) state_d = IDLE;
          else begin
            imm_d   = seq_byte;
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end
        // A dropped run_en leaves the instruction held; it can still be taken.
        HOLD: begin
          if (instr_ready_i) begin
            valid_d = 1'b0;
            pc_d    = pc_q + instr_len(op_q);
            state_d = IDLE;
            if (run_en_i) begin
              go_fetch = 1'b1;
              go_addr  = pc_q + instr_len(op_q);
            end
          end
        end
`ifdef FETCH_ROM_LIMIT_EN
        FAULT: state_d = FAULT;
`endif
        default: state_d = IDLE;
      endcase
    end

    if (go_fetch) begin
`ifdef FETCH_ROM_LIMIT_EN
      if (go_addr > ROM_TOP) begin
        state_d = FAULT;
        fault_d = 1'b1;
        valid_d = 1'b0;
      end else
`endif
      begin
        state_d = go_imm ? IM_ADDR : OP_ADDR;
        phase_d = BP_ADDR;
        addr_d  = go_addr;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ipc_q   <= 16'h0000;
      op_q    <= 8'h00;
      imm_q   <= 8'h00;
      valid_q <= 1'b0;
`ifdef FETCH_ROM_LIMIT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      valid_q <= valid_d;
`ifdef FETCH_ROM_LIMIT_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign instr_valid_o = valid_q;
  assign instr_op_o    = op_q;
  assign instr_imm_o   = imm_q;
  assign instr_pc_o    = ipc_q;
  assign pc_o          = pc_q;
`ifdef FETCH_ROM_LIMIT_EN
  assign fault_o       = fault_q;
`else
  assign fault_o       = 1'b0;
`endif

endmodule
